// File: rtl/sample_arbiter_pkg.sv
// rtl/sample_arbiter_pkg.sv - shared widths, source indices and helpers for the sample arbiter
package sample_arbiter_pkg;

   localparam int SAMPLE_W_DEF = 48;
   localparam int DROP_W_DEF   = 16;

   localparam int SRC_APD      = 0;
   localparam int SRC_STATUS   = 1;

   // Width of a source index; a single source still needs a one-bit grant_id.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sample_arb_slot.sv
// rtl/sample_arb_slot.sv - one-entry hold register with valid flag and saturating drop counter
module sample_arb_slot
   import sample_arbiter_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int DROP_W   = DROP_W_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rdy_i,
   input  logic [SAMPLE_W-1:0] data_i,
   input  logic                grant_i,
   input  logic                drop_clr_i,
   output logic                valid_o,
   output logic [SAMPLE_W-1:0] data_o,
   output logic [DROP_W-1:0]   drop_count_o
);

   logic                valid_q, valid_d;
   logic [SAMPLE_W-1:0] data_q, data_d;
   logic [DROP_W-1:0]   cnt_q, cnt_d;
   logic                load, drop;

   // A slot being granted this cycle frees up in time to accept a new word.
   assign load = rdy_i & (~valid_q | grant_i);
   assign drop = rdy_i & valid_q & ~grant_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (grant_i) begin
         valid_d = 1'b0;
      end
      // A clear that coincides with a drop keeps that drop counted.
      if (drop_clr_i) begin
         cnt_d = drop ? DROP_W'(1) : '0;
      end else if (drop && (cnt_q != {DROP_W{1'b1}})) begin
         cnt_d = cnt_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_o      = valid_q;
   assign data_o       = data_q;
   assign drop_count_o = cnt_q;

endmodule

// File: rtl/sample_arbiter.sv
// rtl/sample_arbiter.sv - round-robin scheduler of strobe-only sample sources onto the sample_fifo write port
module sample_arbiter
   import sample_arbiter_pkg::*;
#(
   parameter int N_SRC    = 2,
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int DROP_W   = DROP_W_DEF
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        operate,
   input  logic [N_SRC-1:0]            src_rdy,
   input  logic [N_SRC*SAMPLE_W-1:0]   src_data,
   input  logic                        fifo_full,
   output logic                        fifo_wrreq,
   output logic [SAMPLE_W-1:0]         fifo_data,
   output logic [idx_w(N_SRC)-1:0]     grant_id,
   input  logic                        drop_clr,
   output logic [N_SRC*DROP_W-1:0]     drop_count
);

   localparam int IDX_W = idx_w(N_SRC);

   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [IDX_W-1:0]    win;
   logic                found, go;
   logic [N_SRC-1:0]    slot_valid;
   logic [N_SRC-1:0]    grant;
   logic [SAMPLE_W-1:0] slot_data [N_SRC];

   for (genvar s = 0; s < N_SRC; s++) begin : g_slot
      sample_arb_slot #(
         .SAMPLE_W (SAMPLE_W),
         .DROP_W   (DROP_W)
      ) u_slot (
         .clk          (clk),
         .reset_n      (reset_n),
         .rdy_i        (src_rdy[s]),
         .data_i       (src_data[s*SAMPLE_W +: SAMPLE_W]),
         .grant_i      (grant[s]),
         .drop_clr_i   (drop_clr),
         .valid_o      (slot_valid[s]),
         .data_o       (slot_data[s]),
         .drop_count_o (drop_count[s*DROP_W +: DROP_W])
      );
   end

   // Scan starts one past the last winner, so the last winner has lowest priority.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 1; i <= N_SRC; i++) begin
         logic [IDX_W-1:0] cand;
         cand = IDX_W'((int'(rr_q) + i) % N_SRC);
         if (!found && slot_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign go = operate & ~fifo_full & found;

   always_comb begin
      grant      = '0;
      fifo_wrreq = go;
      fifo_data  = '0;
      grant_id   = '0;
      rr_d       = rr_q;
      if (go) begin
         grant[win] = 1'b1;
         fifo_data  = slot_data[win];
         grant_id   = win;
         rr_d       = win;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_q <= IDX_W'(N_SRC - 1);
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule

// File: tb/tb_sample_arbiter.sv
// tb/tb_sample_arbiter.sv - self-checking bench for sample_arbiter against a behavioural model
module tb_sample_arbiter;

   localparam int N  = 2;
   localparam int SW = 48;
   localparam int DW = 4;
   localparam int DMAX = (1 << DW) - 1;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            operate;
   logic [N-1:0]    src_rdy;
   logic [N*SW-1:0] src_data;
   logic            fifo_full;
   logic            fifo_wrreq;
   logic [SW-1:0]   fifo_data;
   logic [0:0]      grant_id;
   logic            drop_clr;
   logic [N*DW-1:0] drop_count;

   sample_arbiter #(.N_SRC(N), .SAMPLE_W(SW), .DROP_W(DW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .operate    (operate),
      .src_rdy    (src_rdy),
      .src_data   (src_data),
      .fifo_full  (fifo_full),
      .fifo_wrreq (fifo_wrreq),
      .fifo_data  (fifo_data),
      .grant_id   (grant_id),
      .drop_clr   (drop_clr),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model: held word per source, drop totals, last served source
   bit          m_valid [N];
   logic [47:0] m_word  [N];
   int          m_drop  [N];
   int          m_last;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < N; s++) begin
         m_valid[s] = 0;
         m_word[s]  = '0;
         m_drop[s]  = 0;
      end
      m_last = N - 1;
   endtask

   // One clock: drive inputs, compare outputs to the model, advance the model.
   task automatic step(input logic [1:0] rdy, input logic [47:0] d0, input logic [47:0] d1,
                       input logic op, input logic full, input logic clr);
      bit exp_go;
      int win;
      @(negedge clk);
      src_rdy   = rdy;
      src_data  = {d1, d0};
      operate   = op;
      fifo_full = full;
      drop_clr  = clr;
      #1;
      exp_go = 0;
      win    = 0;
      if (op && !full) begin
         for (int i = 1; i <= N; i++) begin
            int c;
            c = (m_last + i) % N;
            if (!exp_go && m_valid[c]) begin
               exp_go = 1;
               win    = c;
            end
         end
      end
      chk("wrreq", 64'(fifo_wrreq), 64'(exp_go));
      chk("data",  64'(fifo_data),  exp_go ? 64'(m_word[win]) : 64'd0);
      chk("gid",   64'(grant_id),   exp_go ? 64'(win) : 64'd0);
      chk("drop0", 64'(drop_count[DW-1:0]),  64'(m_drop[0]));
      chk("drop1", 64'(drop_count[2*DW-1:DW]), 64'(m_drop[1]));
      if (exp_go) m_last = win;
      for (int s = 0; s < N; s++) begin
         bit granted, dropped;
         granted = exp_go && (win == s);
         dropped = 0;
         if (rdy[s]) begin
            if (!m_valid[s] || granted) begin
               m_valid[s] = 1;
               m_word[s]  = (s == 0) ? d0 : d1;
            end else begin
               dropped = 1;
            end
         end else if (granted) begin
            m_valid[s] = 0;
         end
         if (clr)          m_drop[s] = dropped ? 1 : 0;
         else if (dropped) m_drop[s] = (m_drop[s] < DMAX) ? m_drop[s] + 1 : DMAX;
      end
   endtask

   initial begin
      logic [47:0] r0, r1, held;
      int saved;
      reset_n = 1'b0; operate = 1'b0; src_rdy = '0; src_data = '0;
      fifo_full = 1'b0; drop_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wrreq", 64'(fifo_wrreq), 0);
      chk("rst_data",  64'(fifo_data),  0);
      chk("rst_gid",   64'(grant_id),   0);
      chk("rst_drop",  64'(drop_count), 0);
      reset_n = 1'b1;

      // single strobe: one-cycle latency
      step(2'b01, 48'h1, 48'h0, 1, 0, 0);
      step(2'b00, 48'h0, 48'h0, 1, 0, 0);
      chk("t1_wr", 64'(fifo_wrreq), 1);
      chk("t1_data", 64'(fifo_data), 48'h1);
      chk("t1_gid", 64'(grant_id), 0);

      // source 1 served last, so a tie goes A then B
      step(2'b10, 48'h0, 48'h5, 1, 0, 0);
      step(2'b11, 48'hA, 48'hB, 1, 0, 0);
      step(2'b00, 48'h0, 48'h0, 1, 0, 0);
      chk("t2_a", 64'(fifo_data), 48'hA);
      step(2'b00, 48'h0, 48'h0, 1, 0, 0);
      chk("t2_b", 64'(fifo_data), 48'hB);
      step(2'b01, 48'hC, 48'h0, 1, 0, 0);
      step(2'b11, 48'hD, 48'hE, 1, 0, 0);
      step(2'b00, 48'h0, 48'h0, 1, 0, 0);
      chk("t2_tie_b", 64'(grant_id), 1);
      chk("t2_tie_bd", 64'(fifo_data), 48'hE);
      repeat (2) step(2'b00, 48'h0, 48'h0, 1, 0, 0);

      // fifo full: one word held, two dropped
      step(2'b00, 48'h0, 48'h0, 1, 0, 1);
      step(2'b01, 48'h11, 48'h0, 1, 1, 0);
      step(2'b00, 48'h0, 48'h0, 1, 1, 0);
      step(2'b01, 48'h12, 48'h0, 1, 1, 0);
      step(2'b00, 48'h0, 48'h0, 1, 1, 0);
      step(2'b01, 48'h13, 48'h0, 1, 1, 0);
      step(2'b00, 48'h0, 48'h0, 1, 0, 0);
      chk("t3_wr", 64'(fifo_wrreq), 1);
      chk("t3_data", 64'(fifo_data), 48'h11);
      chk("t3_drop", 64'(drop_count[DW-1:0]), 2);

      // grant and reload in the same cycle
      step(2'b01, 48'h21, 48'h0, 1, 1, 0);
      saved = int'(drop_count[DW-1:0]);
      step(2'b01, 48'h22, 48'h0, 1, 0, 0);
      chk("t4_old", 64'(fifo_data), 48'h21);
      step(2'b00, 48'h0, 48'h0, 1, 0, 0);
      chk("t4_new", 64'(fifo_data), 48'h22);
      chk("t4_drop", 64'(drop_count[DW-1:0]), 64'(saved));

      // saturation and clear coincident with a drop
      step(2'b00, 48'h0, 48'h0, 1, 0, 1);
      repeat (20) step(2'b10, 48'h0, 48'h31, 1, 1, 0);
      step(2'b10, 48'h0, 48'h32, 1, 1, 1);
      chk("t5_sat", 64'(drop_count[2*DW-1:DW]), DMAX);
      step(2'b00, 48'h0, 48'h0, 1, 1, 0);
      chk("t5_clr", 64'(drop_count[2*DW-1:DW]), 1);
      chk("t5_clr0", 64'(drop_count[DW-1:0]), 0);

      // reset mid-stream with both slots full
      step(2'b11, 48'h41, 48'h42, 1, 1, 0);
      step(2'b00, 48'h0, 48'h0, 1, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_wr", 64'(fifo_wrreq), 0);
      chk("t6_cnt", 64'(drop_count), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) step(2'b00, 48'h0, 48'h0, 1, 0, 0);
      chk("t6_stale", 64'(fifo_wrreq), 0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         r0 = 48'({$urandom, $urandom});
         r1 = 48'({$urandom, $urandom});
         step(2'($urandom_range(0, 3)), r0, r1,
              ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3),
              ($urandom_range(0, 49) == 0));
      end
      held = '0;
      step(2'b00, held, held, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
